// File: rtl/chunked_add_sub.sv
// chunked_add_sub
//   Multi-cycle adder/subtractor. A WIDTH-bit add or subtract is processed
//   CHUNK bits per clock through one CHUNK-bit adder slice. The carry is kept
//   in a flop between chunks, so an operation takes N = WIDTH/CHUNK clocks.
//
// Parameters
//   WIDTH  operand/result width; must be an integer multiple of CHUNK
//   CHUNK  bits per cycle, 1 <= CHUNK <= WIDTH
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, accepted only in IDLE or DONE
//   sub    0: s = a + b + cin   1: s = a - b - cin
//   cin    carry-in (add) / borrow-in (sub)
//   a, b   operands (unsigned or two's complement)
//   busy   high while chunks are processed
//   done   one-cycle pulse when s/cout/ovf are valid
//   s      result, held until the next accepted start
//   cout   carry out of MSB (sub: 1 = no borrow)
//   ovf    signed overflow
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             slice_cout;
  logic             msb_cin;

  assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_chunk = (idx_q == LAST_IDX);

  // Operand registers shift right one chunk per cycle, so the slice always
  // reads the low chunk and no variable-index mux is needed on the inputs.
  assign a_chunk = a_q[CHUNK-1:0];
  assign b_chunk = b_q[CHUNK-1:0];
  assign {slice_cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                 + {{CHUNK{1'b0}}, carry_q};
  // Carry into the slice's top bit, recovered from sum = a ^ b ^ carry_in.
  assign msb_cin = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (accept) begin
      // Subtraction is a + ~b + 1; a borrow-in removes the +1.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin ^ sub;
      idx_d   = '0;
      s_d     = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      carry_d = slice_cout;
      idx_d   = idx_q + IDX_W'(1);
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) s_d[i*CHUNK +: CHUNK] = sum_chunk;
      end
      if (last_chunk) begin
        cout_d = slice_cout;
        ovf_d  = msb_cin ^ slice_cout;
        idx_d  = '0;
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    s    = s_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_chunked_add_sub.sv
module tb_chunked_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit / 4-bit chunk instance
  logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, s16;
  // 4-bit / 4-bit chunk instance
  logic        start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, s4;
  // 8-bit / 1-bit chunk instance
  logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, s8;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .s(s16),
    .cout(cout16), .ovf(ovf16));

  chunked_add_sub #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .s(s4),
    .cout(cout4), .ovf(ovf4));

  chunked_add_sub #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .s(s8),
    .cout(cout8), .ovf(ovf8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op on u16 and wait for done; lat counts edges from accept to done.
  task automatic run16(input logic sb, input logic ci, input logic [15:0] aa,
                       input logic [15:0] bb, output int lat, output int busy_cnt);
    @(negedge clk);
    sub16 = sb; cin16 = ci; a16 = aa; b16 = bb; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done16 && lat < 64) begin
      if (busy16) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  // Global time bound
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_cnt, k, d;

    vecs[0]  = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0010, 16'h0005, 16'h000A, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    start4  = 0; sub4  = 0; cin4  = 0; a4  = '0; b4  = '0;
    start8  = 0; sub8  = 0; cin8  = 0; a8  = '0; b8  = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_busy16", busy16, 0); chk("rst_done16", done16, 0);
    chk("rst_s16", s16, 0); chk("rst_cout16", cout16, 0); chk("rst_ovf16", ovf16, 0);
    chk("rst_out4", {busy4, done4, s4, cout4, ovf4}, 0);
    chk("rst_out8", {busy8, done8, s8, cout8, ovf8}, 0);
    $display("reset: busy=%0d done=%0d s=%h", busy16, done16, s16);
    rst = 1'b0;

    // Table-driven vectors on the 16/4 instance
    for (int i = 0; i < 12; i++) begin
      run16(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat, busy_cnt);
      chk("done", done16, 1);
      chk("latency", lat, 4);
      chk("busy_cycles", busy_cnt, 4);
      chk("s", s16, vecs[i].s);
      chk("cout", cout16, vecs[i].cout);
      chk("ovf", ovf16, vecs[i].ovf);
      @(negedge clk);
      chk("done_pulse", done16, 0);
      chk("s_hold", s16, vecs[i].s);
      $display("vec %0d: sub=%0d cin=%0d a=%h b=%h -> s=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, s16, cout16, ovf16, lat);
    end

    // start while busy is ignored
    @(negedge clk);
    sub16 = 0; cin16 = 0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    @(negedge clk);                 // after E0
    start16 = 1'b0;
    @(negedge clk);                 // after E0+1
    sub16 = 1; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(negedge clk);                 // after E0+2
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 64) begin @(negedge clk); k++; end
    chk("ign_done", done16, 1);
    chk("ign_lat", k, 2);
    chk("ign_s", s16, 16'h5555);
    chk("ign_cout_ovf", {cout16, ovf16}, 2'b00);
    @(negedge clk);
    chk("ign_idle_busy", busy16, 0);
    chk("ign_idle_done", done16, 0);
    $display("ignore-start: s=%h lat=%0d", s16, k + 2);

    // start held through DONE -> back-to-back op, operands changed after E0
    @(negedge clk);
    sub16 = 0; cin16 = 0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    @(negedge clk);                 // after E0
    a16 = 16'h7FFF; b16 = 16'h0001;
    k = 0;
    while (!done16 && k < 64) begin @(negedge clk); k++; end
    chk("b2b_done1", done16, 1);
    chk("b2b_s1", s16, 16'h5555);
    chk("b2b_cout_ovf1", {cout16, ovf16}, 2'b00);
    @(negedge clk);
    start16 = 1'b0;
    chk("b2b_busy2", busy16, 1);
    d = 1;
    while (!done16 && d < 64) begin @(negedge clk); d++; end
    chk("b2b_done2", done16, 1);
    chk("b2b_gap", d, 5);
    chk("b2b_s2", s16, 16'h8000);
    chk("b2b_cout_ovf2", {cout16, ovf16}, 2'b01);
    $display("back-to-back: s1=5555 s2=%h gap=%0d", s16, d);

    // Asynchronous reset mid-run
    @(negedge clk);
    @(negedge clk);
    sub16 = 0; cin16 = 0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    @(negedge clk);                 // after E0
    start16 = 1'b0;
    @(posedge clk);                 // E0+1
    @(posedge clk);                 // E0+2
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy16, 0); chk("arst_done", done16, 0);
    chk("arst_s", s16, 0); chk("arst_cout", cout16, 0); chk("arst_ovf", ovf16, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run16(1'b0, 1'b0, 16'h7FFF, 16'h0001, lat, busy_cnt);
    chk("arst_new_lat", lat, 4);
    chk("arst_new_s", s16, 16'h8000);
    chk("arst_new_cout_ovf", {cout16, ovf16}, 2'b01);
    $display("async-reset: after restart s=%h lat=%0d", s16, lat);

    // Exhaustive 4/4 sweep and 8/1 sweep (a exhaustive, b at boundary values)
    fork
      begin
        for (int si = 0; si < 2; si++) begin
          for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
              for (int ib = 0; ib < 16; ib++) begin
                int u, r, sa, sbv, kk;
                logic [3:0] es;
                logic ec, eo;
                @(negedge clk);
                sub4 = (si != 0); cin4 = (ci != 0);
                a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                kk = 0;
                while (!done4 && kk < 16) begin @(negedge clk); kk++; end
                sa  = (ia >= 8) ? ia - 16 : ia;
                sbv = (ib >= 8) ? ib - 16 : ib;
                if (si == 0) begin
                  u = ia + ib + ci;
                  r = sa + sbv + ci;
                end else begin
                  u = ia + (15 - ib) + (1 - ci);
                  r = sa - sbv - ci;
                end
                es = 4'(u % 16);
                ec = (u >= 16);
                eo = (r < -8) || (r > 7);
                chk("w4_done", done4, 1);
                chk("w4_lat", kk, 1);
                chk("w4_res", {ovf4, cout4, s4}, {eo, ec, es});
              end
            end
            $display("w4 sweep: sub=%0d cin=%0d errors=%0d", si, ci, errors);
          end
        end
      end
      begin
        int bvals[5];
        bvals[0] = 0; bvals[1] = 1; bvals[2] = 8'h7F; bvals[3] = 8'h80; bvals[4] = 8'hFF;
        for (int si = 0; si < 2; si++) begin
          for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 256; ia++) begin
              for (int j = 0; j < 5; j++) begin
                int u, r, sa, sbv, kk, ib;
                logic [7:0] es;
                logic ec, eo;
                ib = bvals[j];
                @(negedge clk);
                sub8 = (si != 0); cin8 = (ci != 0);
                a8 = 8'(ia); b8 = 8'(ib); start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                kk = 0;
                while (!done8 && kk < 32) begin @(negedge clk); kk++; end
                sa  = (ia >= 128) ? ia - 256 : ia;
                sbv = (ib >= 128) ? ib - 256 : ib;
                if (si == 0) begin
                  u = ia + ib + ci;
                  r = sa + sbv + ci;
                end else begin
                  u = ia + (255 - ib) + (1 - ci);
                  r = sa - sbv - ci;
                end
                es = 8'(u % 256);
                ec = (u >= 256);
                eo = (r < -128) || (r > 127);
                chk("w8_done", done8, 1);
                chk("w8_lat", kk, 8);
                chk("w8_res", {ovf8, cout8, s8}, {eo, ec, es});
              end
            end
            $display("w8 sweep: sub=%0d cin=%0d errors=%0d", si, ci, errors);
          end
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
